// File: rtl/led_cmd_rx.sv
// led_cmd_rx: UART (8N1) receiver feeding a 4-byte LED command parser.
// Frame: A5, idx (0..7), val, chk = {5'b0,idx} ^ val.
// Accepted frames pulse cmd_valid and update cmd_idx/cmd_val. Bad frames
// pulse err instead. A bad frame is a framing, index or checksum error.
// cmd_valid and err are registered one cycle after the stop-bit sample.
// They are never high in the same cycle.
// Optional feature macro: LED_CMD_TIMEOUT_EN. When it is defined, the parser
// returns to HUNT with an err pulse after it sits outside HUNT for 20 bit
// times without receiving a byte.
module led_cmd_rx #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       cmd_valid,
    output logic [2:0] cmd_idx,
    output logic [7:0] cmd_val,
    output logic       err,
    output logic       rx_busy
);

    localparam int DIV  = CLK_FREQ / BAUD;
    localparam int HALF = DIV / 2;
    localparam logic [15:0] DIV_LAST  = 16'(DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF - 1);

    // UART receiver states
    localparam logic [1:0] U_IDLE  = 2'd0;
    localparam logic [1:0] U_START = 2'd1;
    localparam logic [1:0] U_DATA  = 2'd2;
    localparam logic [1:0] U_STOP  = 2'd3;

    // Command parser states
    localparam logic [1:0] P_HUNT = 2'd0;
    localparam logic [1:0] P_IDX  = 2'd1;
    localparam logic [1:0] P_VAL  = 2'd2;
    localparam logic [1:0] P_CHK  = 2'd3;

    localparam logic [7:0] HEADER = 8'hA5;

    // Synchronizer
    logic rx_meta_q, rx_sync_q;

    // UART receiver state
    logic [1:0]  u_state_q, u_state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        busy_q, busy_d;
    logic        byte_stb;
    logic        frame_err;

    // Parser state and outputs
    logic [1:0] p_state_q, p_state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] val_q, val_d;
    logic [2:0] cmd_idx_q, cmd_idx_d;
    logic [7:0] cmd_val_q, cmd_val_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic       err_q, err_d;

`ifdef LED_CMD_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(20 * DIV - 1);
    logic [31:0] tmo_q, tmo_d;
    logic        tmo_fire;
`endif

    // Two-flop synchronizer for the asynchronous line; both flops idle high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // UART next state: the start bit is checked at mid-bit, then every later bit is sampled one bit time apart
    always_comb begin
        u_state_d = u_state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        busy_d    = busy_q;
        byte_stb  = 1'b0;
        frame_err = 1'b0;
        case (u_state_q)
            U_IDLE: begin
                if (!rx_sync_q) begin
                    u_state_d = U_START;
                    cnt_d     = 16'd0;
                    busy_d    = 1'b1;
                end
            end
            U_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = 16'd0;
                    if (!rx_sync_q) begin
                        u_state_d = U_DATA;
                        bit_d     = 3'd0;
                    end else begin
                        // line went back high: a glitch, not a start bit
                        u_state_d = U_IDLE;
                        busy_d    = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            U_DATA: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = 16'd0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        u_state_d = U_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            U_STOP: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d     = 16'd0;
                    busy_d    = 1'b0;
                    u_state_d = U_IDLE;
                    if (rx_sync_q) begin
                        byte_stb = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                u_state_d = U_IDLE;
            end
        endcase
    end

    // UART registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_state_q <= U_IDLE;
            cnt_q     <= 16'd0;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            busy_q    <= 1'b0;
        end else begin
            u_state_q <= u_state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            busy_q    <= busy_d;
        end
    end

`ifdef LED_CMD_TIMEOUT_EN
    assign tmo_fire = (p_state_q != P_HUNT) && (tmo_q == TMO_LAST);

    // Inactivity counter: runs only while a frame is partially received
    always_comb begin
        tmo_d = tmo_q + 32'd1;
        if (byte_stb || frame_err || tmo_fire || (p_state_q == P_HUNT)) begin
            tmo_d = 32'd0;
        end
    end

    // Timeout counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= 32'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    // Parser next state: the byte is consumed in the same cycle it is strobed, so outputs land one cycle later
    always_comb begin
        p_state_d   = p_state_q;
        idx_d       = idx_q;
        val_d       = val_q;
        cmd_idx_d   = cmd_idx_q;
        cmd_val_d   = cmd_val_q;
        cmd_valid_d = 1'b0;
        err_d       = 1'b0;
        if (frame_err) begin
            p_state_d = P_HUNT;
            err_d     = 1'b1;
        end else if (byte_stb) begin
            case (p_state_q)
                P_HUNT: begin
                    if (shift_q == HEADER) begin
                        p_state_d = P_IDX;
                    end
                end
                P_IDX: begin
                    // any out-of-range value, including a second header, aborts the frame
                    if (shift_q[7:3] == 5'd0) begin
                        idx_d     = shift_q[2:0];
                        p_state_d = P_VAL;
                    end else begin
                        err_d     = 1'b1;
                        p_state_d = P_HUNT;
                    end
                end
                P_VAL: begin
                    val_d     = shift_q;
                    p_state_d = P_CHK;
                end
                P_CHK: begin
                    if (shift_q == ({5'b0, idx_q} ^ val_q)) begin
                        cmd_idx_d   = idx_q;
                        cmd_val_d   = val_q;
                        cmd_valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    p_state_d = P_HUNT;
                end
                default: begin
                    p_state_d = P_HUNT;
                end
            endcase
        end
`ifdef LED_CMD_TIMEOUT_EN
        else if (tmo_fire) begin
            err_d     = 1'b1;
            p_state_d = P_HUNT;
        end
`endif
    end

    // Parser and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state_q   <= P_HUNT;
            idx_q       <= 3'd0;
            val_q       <= 8'd0;
            cmd_idx_q   <= 3'd0;
            cmd_val_q   <= 8'd0;
            cmd_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            p_state_q   <= p_state_d;
            idx_q       <= idx_d;
            val_q       <= val_d;
            cmd_idx_q   <= cmd_idx_d;
            cmd_val_q   <= cmd_val_d;
            cmd_valid_q <= cmd_valid_d;
            err_q       <= err_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_idx   = cmd_idx_q;
    assign cmd_val   = cmd_val_q;
    assign err       = err_q;
    assign rx_busy   = busy_q;

endmodule

// File: tb/tb_led_cmd_rx.sv
// Directed bench for led_cmd_rx at default CLK_FREQ/BAUD.
module tb_led_cmd_rx;
  localparam int CLK_FREQ = 25_000_000;
  localparam int BAUD     = 115_200;
  localparam int DIV      = CLK_FREQ / BAUD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       cmd_valid;
  logic [2:0] cmd_idx;
  logic [7:0] cmd_val;
  logic       err;
  logic       rx_busy;

  int n_cmp = 0;
  int n_fail = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  logic prev_busy = 1'b0;
  int v0, e0;

  led_cmd_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .cmd_valid(cmd_valid),
    .cmd_idx(cmd_idx), .cmd_val(cmd_val), .err(err), .rx_busy(rx_busy)
  );

  // clock / reset block
  always #20 clk = ~clk;

  // pulse monitor: counts pulses, checks exclusivity and 1-cycle latency after the stop sample
  always @(negedge clk) begin
    if (cmd_valid === 1'b1) begin
      valid_cnt++;
      n_cmp++;
      if (err !== 1'b0 || prev_busy !== 1'b1 || rx_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL valid_pulse: err=%b prev_busy=%b busy=%b, want err=0 prev_busy=1 busy=0",
                 err, prev_busy, rx_busy);
      end
    end
    if (err === 1'b1) err_cnt++;
    prev_busy = rx_busy;
  end

  // driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rx = 1'b0;
    wait_cyc(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(DIV);
    end
    if (bad_stop) begin
      // low through the stop sample, then high long enough for the false start to be rejected
      rx = 1'b0;
      wait_cyc(144);
      rx = 1'b1;
      wait_cyc(2 * DIV - 144);
    end else begin
      rx = 1'b1;
      wait_cyc(DIV);
    end
  endtask

  task automatic send4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    send_byte(a, 1'b0);
    send_byte(b, 1'b0);
    send_byte(c, 1'b0);
    send_byte(d, 1'b0);
  endtask

  task automatic snap();
    v0 = valid_cnt;
    e0 = err_cnt;
  endtask

  task automatic check_counts(input string name, input int want_v, input int want_e);
    n_cmp++;
    if (valid_cnt - v0 != want_v) begin
      n_fail++;
      $display("FAIL %s_valid: got %0d pulses, want %0d", name, valid_cnt - v0, want_v);
    end
    n_cmp++;
    if (err_cnt - e0 != want_e) begin
      n_fail++;
      $display("FAIL %s_err: got %0d pulses, want %0d", name, err_cnt - e0, want_e);
    end
  endtask

  task automatic check_cmd(input string name, input logic [2:0] want_idx, input logic [7:0] want_val);
    n_cmp++;
    if (cmd_idx !== want_idx) begin
      n_fail++;
      $display("FAIL %s_idx: got %0d, want %0d", name, cmd_idx, want_idx);
    end
    n_cmp++;
    if (cmd_val !== want_val) begin
      n_fail++;
      $display("FAIL %s_val: got %02h, want %02h", name, cmd_val, want_val);
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    wait_cyc(5);
    n_cmp++;
    if (cmd_valid !== 1'b0 || err !== 1'b0 || rx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: valid=%b err=%b busy=%b, want 0 0 0", cmd_valid, err, rx_busy);
    end
    check_cmd("reset", 3'd0, 8'h00);
    snap();
    rst_n = 1'b1;
    wait_cyc(20);
    check_counts("reset_release", 0, 0);
  endtask

  task automatic test_cmd_ok();
    snap();
    send4(8'hA5, 8'h03, 8'h80, 8'h83);
    wait_cyc(4);
    check_counts("cmd_ok", 1, 0);
    check_cmd("cmd_ok", 3'd3, 8'h80);
  endtask

  task automatic test_bad_chk();
    snap();
    send4(8'hA5, 8'h03, 8'h80, 8'h00);
    wait_cyc(4);
    check_counts("bad_chk", 0, 1);
    check_cmd("bad_chk", 3'd3, 8'h80);
  endtask

  task automatic test_framing();
    snap();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h03, 1'b1);
    send4(8'hA5, 8'h05, 8'h10, 8'h15);
    wait_cyc(4);
    check_counts("framing", 1, 1);
    check_cmd("framing", 3'd5, 8'h10);
  endtask

  task automatic test_glitch();
    snap();
    rx = 1'b0;
    wait_cyc(30);
    n_cmp++;
    if (rx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_busy_hi: got %b, want 1", rx_busy);
    end
    wait_cyc(20);
    rx = 1'b1;
    wait_cyc(300);
    n_cmp++;
    if (rx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_busy_lo: got %b, want 0", rx_busy);
    end
    check_counts("glitch", 0, 0);
    check_cmd("glitch", 3'd5, 8'h10);
  endtask

  task automatic test_index_err();
    snap();
    send4(8'hA5, 8'hA5, 8'hA5, 8'h09);
    wait_cyc(4);
    check_counts("index_err", 0, 2);
  endtask

  task automatic test_reset_mid();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h03, 1'b0);
    rx = 1'b0;
    wait_cyc(500);
    n_cmp++;
    if (rx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_busy_before: got %b, want 1", rx_busy);
    end
    snap();
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if (rx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_busy_in_reset: got %b, want 0", rx_busy);
    end
    check_cmd("rst_mid_in_reset", 3'd0, 8'h00);
    rx = 1'b1;
    wait_cyc(10);
    rst_n = 1'b1;
    wait_cyc(2 * DIV);
    check_counts("rst_mid_release", 0, 0);
    snap();
    send_byte(8'h80, 1'b0);
    send_byte(8'h83, 1'b0);
    wait_cyc(4);
    check_counts("rst_mid_tail", 0, 0);
    snap();
    send4(8'hA5, 8'h07, 8'hFF, 8'hF8);
    wait_cyc(4);
    check_counts("rst_mid_cmd", 1, 0);
    check_cmd("rst_mid_cmd", 3'd7, 8'hFF);
  endtask

  task automatic test_timeout();
    snap();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h03, 1'b0);
    wait_cyc(25 * DIV);
    send_byte(8'h80, 1'b0);
    send_byte(8'h83, 1'b0);
    wait_cyc(4);
`ifdef LED_CMD_TIMEOUT_EN
    check_counts("timeout", 0, 1);
    check_cmd("timeout", 3'd7, 8'hFF);
`else
    check_counts("timeout", 1, 0);
    check_cmd("timeout", 3'd3, 8'h80);
`endif
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_cmd_ok();
    test_bad_chk();
    test_framing();
    test_glitch();
    test_index_err();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
